// File: rtl/x_seq.sv
// Micro-sequencer for the X pointer register: decodes a latched opcode into x/accumulator bus controls.
// Optional feature: define X_SEQ_JXM_EN to make opcode 8'h07 (JXM, jump on X minus) legal.
module x_seq #(
  parameter int OPW = 8
) (
  input  logic           clk,
  input  logic           clr_n,
  input  logic           start,
  input  logic [OPW-1:0] opcode,
  input  logic           im,
  input  logic           iz,
  output logic           lx,
  output logic           ex,
  output logic           inx,
  output logic           dex,
  output logic           la,
  output logic           ea,
  output logic           jmp,
  output logic           busy,
  output logic           done,
  output logic           err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EX1  = 2'd1,
    S_EX2  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [OPW-1:0] OP_TAX   = OPW'(8'h01);
  localparam logic [OPW-1:0] OP_TXA   = OPW'(8'h02);
  localparam logic [OPW-1:0] OP_INX   = OPW'(8'h03);
  localparam logic [OPW-1:0] OP_DEX   = OPW'(8'h04);
  localparam logic [OPW-1:0] OP_JXZ   = OPW'(8'h05);
  localparam logic [OPW-1:0] OP_DXJNZ = OPW'(8'h06);
  localparam logic [OPW-1:0] OP_JXM   = OPW'(8'h07);

  state_t         r_state;
  state_t         w_next;
  logic [OPW-1:0] r_op;

  logic w_tax, w_txa, w_inx, w_dex, w_jxz, w_dxjnz, w_jxm, w_legal;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_op <= opcode;
      end
    end
  end

  assign w_tax   = (r_op == OP_TAX);
  assign w_txa   = (r_op == OP_TXA);
  assign w_inx   = (r_op == OP_INX);
  assign w_dex   = (r_op == OP_DEX);
  assign w_jxz   = (r_op == OP_JXZ);
  assign w_dxjnz = (r_op == OP_DXJNZ);

`ifdef X_SEQ_JXM_EN
  assign w_jxm = (r_op == OP_JXM);
`else
  // 8'h07 falls through to the illegal path; the minus flag has no consumer.
  logic w_unused_im;
  assign w_jxm       = 1'b0;
  assign w_unused_im = im ^ (r_op == OP_JXM);
`endif

  assign w_legal = w_tax | w_txa | w_inx | w_dex | w_jxz | w_dxjnz | w_jxm;

  always_comb begin
    w_next = r_state;
    lx     = 1'b0;
    ex     = 1'b0;
    inx    = 1'b0;
    dex    = 1'b0;
    la     = 1'b0;
    ea     = 1'b0;
    jmp    = 1'b0;
    busy   = (r_state != S_IDLE);
    done   = 1'b0;
    err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_EX1;
      end
      S_EX1: begin
        ea     = w_tax;
        lx     = w_tax;
        ex     = w_txa;
        la     = w_txa;
        inx    = w_inx;
        dex    = w_dex | w_dxjnz;
        jmp    = (w_jxz & iz) | (w_jxm & im);
        w_next = w_dxjnz ? S_EX2 : S_DONE;
      end
      S_EX2: begin
        // x has already decremented, so iz reflects the new value
        jmp    = w_dxjnz & ~iz;
        w_next = S_DONE;
      end
      S_DONE: begin
        done   = 1'b1;
        err    = ~w_legal;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule
